// File: rtl/comp_iter_pkg.sv
// Shared core constants for the iterative branch comparator: branch funct3 codes,
// default operand/opcode widths and the branch-resolution helper.
package comp_iter_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int OPLEN_DEF = 8;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_JMP  = 3'b010;
  localparam logic [2:0] FUNCT3_ILL  = 3'b011;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  // Final taken/not-taken decision once the whole-operand relations are known.
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic       eq_all,
                                        input logic       lt_s,
                                        input logic       lt_u);
    logic taken;
    taken = 1'b0;
    case (f3)
      FUNCT3_BEQ:  taken = eq_all;
      FUNCT3_BNE:  taken = !eq_all;
      FUNCT3_JMP:  taken = 1'b1;
      FUNCT3_ILL:  taken = 1'b0;
      FUNCT3_BLT:  taken = lt_s;
      FUNCT3_BGE:  taken = !lt_s;
      FUNCT3_BLTU: taken = lt_u;
      FUNCT3_BGEU: taken = !lt_u;
      default:     taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/comp_iter_chunk.sv
// Combinational compare of one CHUNK-bit slice: equality, unsigned and signed less-than.
module comp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             eq,
  output logic             lt_u,
  output logic             lt_s
);

  logic signed [CHUNK-1:0] a_s;
  logic signed [CHUNK-1:0] b_s;

  assign a_s  = a;
  assign b_s  = b;
  assign eq   = (a == b);
  assign lt_u = (a < b);
  assign lt_s = (a_s < b_s);

endmodule

// File: rtl/comp_iter.sv
// Iterative branch comparator: walks the operands one chunk per cycle, MSB chunk
// first, and stops on the first differing chunk.
module comp_iter
  import comp_iter_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CHUNK = 8,
  parameter int OPLEN = OPLEN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [XLEN-1:0]  rs1data_de,
  input  logic [XLEN-1:0]  rs2data_de,
  input  logic [OPLEN-1:0] decoded_op_de,
  output logic             ready,
  output logic             done,
  output logic             jump_state,
  output logic             illegal_op
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_TOP = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [2:0]      funct3_q;
  logic [KW-1:0]   k;
  logic [KW-1:0]   k_nx;
  logic            jump_nx;
  logic            illegal_nx;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic             c_eq;
  logic             c_lt_u;
  logic             c_lt_s;
  logic             lt_sel;
  logic             single_cycle;
  logic             run_exit;
  logic             accept;

  assign ready  = (state == S_IDLE);
  assign done   = (state == S_DONE);
  assign accept = start && ready && !flush;

  // Only the sign-carrying top chunk is compared signed.
  assign chunk_a = CHUNK'(rs1_q >> (int'(k) * CHUNK));
  assign chunk_b = CHUNK'(rs2_q >> (int'(k) * CHUNK));
  assign lt_sel  = (k == K_TOP) ? c_lt_s : c_lt_u;

  comp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (chunk_a),
    .b    (chunk_b),
    .eq   (c_eq),
    .lt_u (c_lt_u),
    .lt_s (c_lt_s)
  );

  assign single_cycle = (funct3_q == FUNCT3_JMP) || (funct3_q == FUNCT3_ILL);
  assign run_exit     = single_cycle || !c_eq || (k == '0);

  always_comb begin
    state_nx   = state;
    k_nx       = k;
    jump_nx    = jump_state;
    illegal_nx = illegal_op;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = S_RUN;
          k_nx     = K_TOP;
        end
      end
      S_RUN: begin
        if (run_exit) begin
          state_nx   = S_DONE;
          // An all-equal walk leaves c_eq high, which forces both lt terms low.
          jump_nx    = branch_taken(funct3_q, c_eq, !c_eq && lt_sel, !c_eq && c_lt_u);
          illegal_nx = (funct3_q == FUNCT3_ILL);
        end else begin
          k_nx = k - 1'b1;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) begin
      state_nx   = S_IDLE;
      jump_nx    = jump_state;
      illegal_nx = illegal_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      k          <= '0;
      jump_state <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state      <= state_nx;
      k          <= k_nx;
      jump_state <= jump_nx;
      illegal_op <= illegal_nx;
    end
  end

  // Operands are frozen at acceptance; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q    <= '0;
      rs2_q    <= '0;
      funct3_q <= '0;
    end else if (accept) begin
      rs1_q    <= rs1data_de;
      rs2_q    <= rs2data_de;
      funct3_q <= decoded_op_de[6:4];
    end
  end

endmodule

// File: tb/tb_comp_iter.sv
// Directed bench for comp_iter: a CHUNK=8 instance and a CHUNK=XLEN instance share stimulus.
module tb_comp_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [7:0]  op;

  logic ready1, done1, js1, il1;
  logic ready2, done2, js2, il2;

  int passed;
  int total;

  comp_iter #(.XLEN(32), .CHUNK(8), .OPLEN(8)) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .flush         (flush),
    .rs1data_de    (rs1),
    .rs2data_de    (rs2),
    .decoded_op_de (op),
    .ready         (ready1),
    .done          (done1),
    .jump_state    (js1),
    .illegal_op    (il1)
  );

  comp_iter #(.XLEN(32), .CHUNK(32), .OPLEN(8)) dut2 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .flush         (flush),
    .rs1data_de    (rs1),
    .rs2data_de    (rs2),
    .decoded_op_de (op),
    .ready         (ready2),
    .done          (done2),
    .jump_state    (js2),
    .illegal_op    (il2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Issue one op; measure cycles from the start cycle to done for both instances.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input bit mutate,
                        input int exp_lat1, input int exp_lat2,
                        input logic exp_j1, input logic exp_il1, input logic exp_j2);
    int lat1;
    int lat2;
    lat1 = -1;
    lat2 = -1;
    @(negedge clk);
    rs1   = a;
    rs2   = b;
    op    = {1'b0, f3, 4'b0011};
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (mutate) begin
      rs1 = ~a;
      rs2 = a ^ 32'h0000_00FF;
      op  = 8'h13;
    end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (done1 && lat1 < 0) lat1 = i;
      if (done2 && lat2 < 0) lat2 = i;
    end
    check({tag, "_lat8"},  lat1, exp_lat1);
    check({tag, "_lat32"}, lat2, exp_lat2);
    check({tag, "_jump8"}, {31'b0, js1}, {31'b0, exp_j1});
    check({tag, "_ill8"},  {31'b0, il1}, {31'b0, exp_il1});
    check({tag, "_jump32"}, {31'b0, js2}, {31'b0, exp_j2});
  endtask

  initial begin
    int seen;
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    rs1    = '0;
    rs2    = '0;
    op     = '0;
    #2;
    check("rst_ready", {31'b0, ready1}, 32'd1);
    check("rst_done",  {31'b0, done1},  32'd0);
    check("rst_jump",  {31'b0, js1},    32'd0);
    check("rst_ill",   {31'b0, il1},    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("beq_eq",     3'b000, 32'h0000_000A, 32'h0000_000A, 1'b1, 5, 2, 1'b1, 1'b0, 1'b1);
    run_op("blt_neg",    3'b100, 32'h8000_0008, 32'h0000_0001, 1'b0, 2, 2, 1'b1, 1'b0, 1'b1);
    run_op("bltu_big",   3'b110, 32'h8000_0008, 32'h0000_0001, 1'b0, 2, 2, 1'b0, 1'b0, 1'b0);
    run_op("bge_eq",     3'b101, 32'h8000_0009, 32'h8000_0009, 1'b0, 5, 2, 1'b1, 1'b0, 1'b1);
    run_op("bgeu_lo",    3'b111, 32'h0000_0001, 32'h0000_0008, 1'b0, 5, 2, 1'b0, 1'b0, 1'b0);
    run_op("bge_signs",  3'b101, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 2, 2, 1'b1, 1'b0, 1'b1);
    run_op("bltu_signs", 3'b110, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 2, 2, 1'b1, 1'b0, 1'b1);
    run_op("illegal",    3'b011, 32'h0000_0005, 32'h0000_0005, 1'b0, 2, 2, 1'b0, 1'b1, 1'b0);
    run_op("jmp",        3'b010, 32'h0000_0001, 32'h0000_0002, 1'b0, 2, 2, 1'b1, 1'b0, 1'b1);
    run_op("bne_lsb",    3'b001, 32'h1234_5678, 32'h1234_5679, 1'b0, 5, 2, 1'b1, 1'b0, 1'b1);
    run_op("bne_eq",     3'b001, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 5, 2, 1'b0, 1'b0, 1'b0);
    run_op("jmp_again",  3'b010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2, 2, 1'b1, 1'b0, 1'b1);

    // Flush during the second RUN cycle of a BNE that would otherwise take 4 chunks.
    @(negedge clk);
    rs1   = 32'h1234_5678;
    rs2   = 32'h1234_5679;
    op    = {1'b0, 3'b001, 4'b0011};
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_ready", {31'b0, ready1}, 32'd1);
    check("flush_jump",  {31'b0, js1},    32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done1) seen++;
      @(negedge clk);
    end
    check("flush_nodone", seen, 0);

    // start and flush together in IDLE: request must be dropped.
    @(negedge clk);
    rs1   = 32'h0000_0003;
    rs2   = 32'h0000_0003;
    op    = {1'b0, 3'b001, 4'b0011};
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 begin
      start = 1'b0;
      flush = 1'b0;
    end
    @(negedge clk);
    check("stflush_ready8",  {31'b0, ready1}, 32'd1);
    check("stflush_ready32", {31'b0, ready2}, 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done1 || done2) seen++;
      @(negedge clk);
    end
    check("stflush_nodone", seen, 0);
    check("stflush_jump", {31'b0, js1}, 32'd1);

    // Asynchronous reset in the middle of a 4-chunk walk.
    @(negedge clk);
    rs1   = 32'h0000_0010;
    rs2   = 32'h0000_0010;
    op    = {1'b0, 3'b000, 4'b0011};
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'b0, ready1}, 32'd1);
    check("midrst_done",  {31'b0, done1},  32'd0);
    check("midrst_jump",  {31'b0, js1},    32'd0);
    check("midrst_ill",   {31'b0, il1},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done1) seen++;
    end
    check("midrst_nodone", seen, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
